// File: rtl/ext_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between several OBI masters.
// An in-order ID FIFO routes each response to the master that issued it.
package obi_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module ext_obi_rr_arbiter #(
   parameter int unsigned  NUM_MASTERS     = 4,
   parameter int unsigned  MAX_OUTSTANDING = 2,
   localparam int unsigned IdxWidth = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  obi_pkg::obi_req_t  [NUM_MASTERS-1:0]     master_req_i,
   output obi_pkg::obi_resp_t [NUM_MASTERS-1:0]     master_resp_o,
   output obi_pkg::obi_req_t                        slave_req_o,
   input  obi_pkg::obi_resp_t                       slave_resp_i,
   output logic [CntWidth-1:0]                      outstanding_o,
   output logic                                     busy_o,
   output logic                                     spurious_rvalid_o
);
   localparam int unsigned PtrWidth = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [IdxWidth-1:0] rr_ptr, locked_idx_q, locked_idx_d, arb_idx, sel;
   logic                lock_q, lock_d, arb_found, sel_valid, full, accept, pop;
   logic [IdxWidth-1:0] fifo_mem [MAX_OUTSTANDING];
   logic [PtrWidth-1:0] wr_ptr, rd_ptr;
   logic [CntWidth-1:0] cnt;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Cyclic search from rr_ptr: first the upper segment, then wrap to 0.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (!arb_found && master_req_i[i].req && i >= int'(rr_ptr)) begin
            arb_found = 1'b1;
            arb_idx   = IdxWidth'(i);
         end
      end
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (!arb_found && master_req_i[i].req) begin
            arb_found = 1'b1;
            arb_idx   = IdxWidth'(i);
         end
      end
   end

   always_comb begin
      sel_valid   = lock_q | arb_found;
      sel         = lock_q ? locked_idx_q : arb_idx;
      full        = (cnt >= CntWidth'(MAX_OUTSTANDING));
      slave_req_o = '0;
      if (sel_valid) slave_req_o = master_req_i[sel];
      if (full)      slave_req_o.req = 1'b0;
      accept      = slave_req_o.req & slave_resp_i.gnt;
      pop         = slave_resp_i.rvalid & (cnt != '0);
   end

   // A presented-but-ungranted request freezes the decision; a full stall does not.
   always_comb begin
      lock_d       = lock_q;
      locked_idx_d = locked_idx_q;
      if (accept) begin
         lock_d = 1'b0;
      end else if (slave_req_o.req) begin
         lock_d       = 1'b1;
         locked_idx_d = sel;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         master_resp_o[i].rdata  = slave_resp_i.rdata;
         master_resp_o[i].gnt    = accept & (sel == IdxWidth'(i));
         master_resp_o[i].rvalid = pop & (fifo_mem[rd_ptr] == IdxWidth'(i));
      end
      spurious_rvalid_o = slave_resp_i.rvalid & (cnt == '0);
      busy_o            = (cnt != '0) | lock_q;
      outstanding_o     = cnt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q       <= 1'b0;
         locked_idx_q <= '0;
         rr_ptr       <= '0;
      end else begin
         lock_q       <= lock_d;
         locked_idx_q <= locked_idx_d;
         if (accept) rr_ptr <= (sel == IdxWidth'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_mem[i] <= '0;
      end else begin
         if (accept) begin
            fifo_mem[wr_ptr] <= sel;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (accept && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !accept) cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_ext_obi_rr_arbiter.sv
// Bench for ext_obi_rr_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ext_obi_rr_arbiter;
   import obi_pkg::*;
   localparam int NM   = 4;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   obi_req_t  [NM-1:0] mreq = '0;
   obi_resp_t [NM-1:0] mresp;
   obi_req_t           sreq;
   obi_resp_t          sresp = '0;
   logic [1:0]         outst;
   logic               busy, spur;
   int passed = 0, total = 0;

   ext_obi_rr_arbiter #(.NUM_MASTERS(NM), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .master_req_i(mreq), .master_resp_o(mresp),
      .slave_req_o(sreq), .slave_resp_i(sresp), .outstanding_o(outst),
      .busy_o(busy), .spurious_rvalid_o(spur));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: pointer, lock flag and a queue of issuing master ids.
   int m_ptr = 0, m_lock = 0, m_lidx = 0;
   int q[$];
   int e_sel;
   logic e_acc, e_pop;
   obi_req_t  e_sreq;
   obi_resp_t [NM-1:0] e_mresp;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_ptr = 0; m_lock = 0; m_lidx = 0; q.delete();
         end
         e_sel = -1;
         if (m_lock != 0) e_sel = m_lidx;
         else for (int k = 0; k < NM; k++)
            if (e_sel < 0 && mreq[(m_ptr + k) % NM].req) e_sel = (m_ptr + k) % NM;
         e_sreq = '0;
         if (e_sel >= 0) begin
            e_sreq = mreq[e_sel];
            if (q.size() >= MAXO) e_sreq.req = 1'b0;
         end
         e_acc = e_sreq.req && sresp.gnt;
         e_pop = sresp.rvalid && q.size() > 0;
         for (int i = 0; i < NM; i++) begin
            e_mresp[i].rdata  = sresp.rdata;
            e_mresp[i].gnt    = e_acc && (i == e_sel);
            e_mresp[i].rvalid = 1'b0;
            if (e_pop) e_mresp[i].rvalid = (q[0] == i);
         end
         chk("m_slave_req", sreq, e_sreq);
         chk("m_master_resp", mresp, e_mresp);
         chk("m_outstanding", outst, q.size());
         chk("m_busy", busy, (q.size() != 0) || (m_lock != 0));
         chk("m_spurious", spur, sresp.rvalid && q.size() == 0);
         @(posedge clk);
         if (rst_n) begin
            if (e_pop) void'(q.pop_front());
            if (e_acc) begin
               q.push_back(e_sel);
               m_ptr  = (e_sel + 1) % NM;
               m_lock = 0;
            end else if (e_sreq.req) begin
               m_lock = 1;
               m_lidx = e_sel;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1, "watchdog");
   end

   task automatic nx(); @(posedge clk); #1; endtask
   task automatic ng(); @(negedge clk); endtask

   function automatic obi_req_t mk(input logic [31:0] a, input logic [31:0] d);
      obi_req_t r;
      r.req = 1'b1; r.we = (d != 0); r.be = 4'hf; r.addr = a; r.wdata = d;
      return r;
   endfunction

   function automatic logic [3:0] gvec();
      logic [3:0] g;
      for (int i = 0; i < NM; i++) g[i] = mresp[i].gnt;
      return g;
   endfunction

   function automatic logic [3:0] rvec();
      logic [3:0] r;
      for (int i = 0; i < NM; i++) r[i] = mresp[i].rvalid;
      return r;
   endfunction

   task automatic do_reset();
      mreq = '0; sresp = '0; rst_n = 1'b0;
      ng(); nx();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      mreq = '0; sresp.gnt = 1'b0;
      for (int k = 0; k < 8 && q.size() > 0; k++) begin
         sresp.rvalid = 1'b1; sresp.rdata = 32'hC0DE_0000 + k;
         nx();
      end
      sresp = '0;
   endtask

   int rr_exp[6] = '{0, 1, 3, 0, 1, 3};

   initial begin
      // reset state
      ng();
      chk("rst_outstanding", outst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_slave_req", sreq, 0);
      chk("rst_master_resp", mresp, 0);
      chk("rst_spurious", spur, 0);
      nx(); rst_n = 1'b1; nx();

      // single read from master 2
      mreq[2] = mk(32'h2000, 0); sresp.gnt = 1'b1;
      ng(); chk("t1_gnt", gvec(), 4'b0100); chk("t1_addr", sreq.addr, 32'h2000);
      nx(); mreq = '0; sresp.gnt = 1'b0;
      ng(); chk("t1_out1", outst, 1);
      nx(); nx(); sresp.rvalid = 1'b1; sresp.rdata = 32'hDEADBEEF;
      ng(); chk("t1_rvalid", rvec(), 4'b0100); chk("t1_rdata", mresp[2].rdata, 32'hDEADBEEF);
      nx(); sresp = '0;
      ng(); chk("t1_out0", outst, 0);
      nx(); mreq[0] = mk(32'h10, 0); mreq[3] = mk(32'h30, 0); sresp.gnt = 1'b1;
      ng(); chk("t1_ptr3", gvec(), 4'b1000);
      nx(); mreq[3] = '0;
      ng(); chk("t1_wrap", gvec(), 4'b0001);
      nx(); drain();

      // continuous requests from 0,1,3
      do_reset();
      mreq[0] = mk(32'h100, 0); mreq[1] = mk(32'h110, 0); mreq[3] = mk(32'h130, 0);
      sresp.gnt = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ng(); chk("t2_rr_order", gvec(), 4'b1 << rr_exp[k]);
         nx(); sresp.rvalid = (q.size() > 0); sresp.rdata = 32'h5000 + k;
      end
      drain();

      // lock holds master 0 while master 1 would win arbitration
      do_reset();
      mreq[0] = mk(32'h50, 0); sresp.gnt = 1'b1;
      nx(); drain();
      mreq[0] = mk(32'h100, 32'hA5A5_0000);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) mreq[1] = mk(32'h200, 32'h5A5A_0000);
         ng();
         chk("t3_lock_addr", sreq.addr, 32'h100);
         chk("t3_lock_wdata", sreq.wdata, 32'hA5A5_0000);
         chk("t3_lock_nognt", gvec(), 4'b0000);
         nx();
      end
      sresp.gnt = 1'b1;
      ng(); chk("t3_gnt_m0", gvec(), 4'b0001); chk("t3_busy", busy, 1);
      nx(); mreq[0] = '0;
      ng(); chk("t3_gnt_m1", gvec(), 4'b0010);
      nx(); drain();

      // outstanding cap
      do_reset();
      mreq[0] = mk(32'h400, 0); sresp.gnt = 1'b1;
      nx(); mreq[0] = '0; mreq[2] = mk(32'h420, 0);
      nx(); mreq[2] = '0; mreq[1] = mk(32'h300, 0);
      for (int c = 0; c < 2; c++) begin
         ng(); chk("t4_full_req", sreq.req, 0); chk("t4_full_out", outst, 2);
         nx();
      end
      sresp.rvalid = 1'b1; sresp.rdata = 32'h4444;
      ng(); chk("t4_oldest", rvec(), 4'b0001); chk("t4_full_rv_req", sreq.req, 0);
      nx(); sresp.rvalid = 1'b0;
      ng(); chk("t4_fwd_req", sreq.req, 1); chk("t4_fwd_addr", sreq.addr, 32'h300);
      chk("t4_fwd_gnt", gvec(), 4'b0010);
      nx(); drain();

      // accept and response in the same cycle
      do_reset();
      mreq[0] = mk(32'h600, 0); sresp.gnt = 1'b1;
      nx(); mreq[0] = '0; mreq[3] = mk(32'h630, 0); sresp.rvalid = 1'b1; sresp.rdata = 32'h1234;
      ng(); chk("t5_rv_m0", rvec(), 4'b0001); chk("t5_gnt_m3", gvec(), 4'b1000);
      chk("t5_out", outst, 1);
      nx(); mreq = '0; sresp = '0;
      ng(); chk("t5_out_after", outst, 1);
      nx(); drain();

      // spurious rvalid and reset with transactions in flight
      do_reset();
      sresp.rvalid = 1'b1; sresp.rdata = 32'hBAD0;
      ng(); chk("t6_spur", spur, 1); chk("t6_no_route", rvec(), 4'b0000);
      nx(); sresp.rvalid = 1'b0;
      ng(); chk("t6_spur_pulse", spur, 0);
      nx(); mreq[0] = mk(32'h700, 0); sresp.gnt = 1'b1;
      nx(); mreq[0] = '0; mreq[1] = mk(32'h710, 0);
      nx(); mreq = '0; sresp = '0;
      ng(); chk("t6_out2", outst, 2);
      nx(); rst_n = 1'b0;
      ng(); chk("t6_rst_out", outst, 0); chk("t6_rst_busy", busy, 0);
      chk("t6_rst_sreq", sreq, 0); chk("t6_rst_mresp", mresp, 0);
      nx(); rst_n = 1'b1; sresp.rvalid = 1'b1; sresp.rdata = 32'hBAD1;
      ng(); chk("t6_late_spur", spur, 1);
      nx(); sresp = '0;
      ng();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
